// File: rtl/brrcv.sv
// Boot-register broadcast receiver.
// Captures a fixed index window of broadcast words and validates ordering.
module brrcv #(
  parameter int BRC   = 128,
  parameter int BRCW  = $clog2(BRC),
  parameter int BRDW  = 256,
  parameter int IDXLO = 1,
  parameter int IDXN  = 3
) (
  input  logic                      clksys,
  input  logic                      sysresetn,
  input  logic                      hold,
  input  logic                      brvld,
  input  logic [BRCW-1:0]           bridx,
  input  logic [BRDW-1:0]           brdat,
  input  logic                      brdone,
  output logic                      brready,
  output logic [IDXN-1:0][BRDW-1:0] cfgdat,
  output logic                      cfgvld,
  output logic [31:0]               cfgsig,
  output logic                      brerr,
  output logic [1:0]                errcode
);

  localparam logic [BRCW-1:0] LO  = BRCW'(IDXLO);
  localparam logic [BRCW-1:0] HI  = BRCW'(IDXLO + IDXN - 1);
  localparam logic [BRCW-1:0] TOP = BRCW'(BRC - 1);

  typedef enum logic [1:0] {
    S_WAIT,
    S_CAPT,
    S_DONE,
    S_FAIL
  } st_t;

  st_t             st;
  logic [BRCW-1:0] nxt;
  logic [BRCW-1:0] nxtin;
  logic            act;
  logic            v;
  logic            inwin;
  logic            seqe;
  logic            prote;
  logic            misse;
  logic            cap;
  logic            fin;

  function automatic logic [31:0] fold(
    input logic [BRDW-1:0] d
  );
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < BRDW / 32; i++)
      f ^= d[i*32 +: 32];
    return f;
  endfunction

  always_comb begin
    act   = (st == S_WAIT) || (st == S_CAPT);
    v     = act && brvld;
    inwin = 1'b0;
    for (int k = 0; k < IDXN; k++)
      if (bridx == BRCW'(IDXLO + k))
        inwin = 1'b1;
    seqe  = v && (bridx != nxt);
    prote = v && !brready;
    cap   = v && inwin && !seqe;
    // A completing word wins over a same-cycle brdone.
    fin   = v && (bridx == HI) && !seqe && !prote;
    misse = act && brdone && !fin;
    nxtin = (bridx == TOP) ? TOP : bridx + 1'b1;
  end

  always_ff @(posedge clksys or negedge sysresetn) begin
    if (!sysresetn) begin
      st      <= S_WAIT;
      nxt     <= '0;
      brready <= 1'b0;
      cfgdat  <= '0;
      cfgvld  <= 1'b0;
      cfgsig  <= '0;
      brerr   <= 1'b0;
      errcode <= 2'd0;
    end else begin
      brready <= ~hold;
      if (v)
        nxt <= nxtin;
      if (cap) begin
        for (int k = 0; k < IDXN; k++)
          if (bridx == BRCW'(IDXLO + k))
            cfgdat[k] <= brdat;
        cfgsig <= {cfgsig[30:0], cfgsig[31]}
                ^ fold(brdat);
      end
      if (seqe || prote || misse) begin
        st    <= S_FAIL;
        brerr <= 1'b1;
        if (seqe)
          errcode <= 2'd1;
        else if (prote)
          errcode <= 2'd3;
        else
          errcode <= 2'd2;
      end else if (fin) begin
        st     <= S_DONE;
        cfgvld <= 1'b1;
      end else if (st == S_WAIT && v && bridx == LO) begin
        st <= S_CAPT;
      end
    end
  end

endmodule

// File: tb/tb_brrcv.sv
// Directed testbench for brrcv.
// Scenario tasks with inline expected-value checks.
module tb_brrcv;

  logic             clksys = 1'b0;
  logic             sysresetn = 1'b0;
  logic             hold = 1'b0;
  logic             brvld = 1'b0;
  logic [6:0]       bridx = '0;
  logic [255:0]     brdat = '0;
  logic             brdone = 1'b0;
  logic             brready;
  logic [2:0][255:0] cfgdat;
  logic             cfgvld;
  logic [31:0]      cfgsig;
  logic             brerr;
  logic [1:0]       errcode;

  int checks = 0;
  int errors = 0;

  brrcv dut (
    .clksys    (clksys),
    .sysresetn (sysresetn),
    .hold      (hold),
    .brvld     (brvld),
    .bridx     (bridx),
    .brdat     (brdat),
    .brdone    (brdone),
    .brready   (brready),
    .cfgdat    (cfgdat),
    .cfgvld    (cfgvld),
    .cfgsig    (cfgsig),
    .brerr     (brerr),
    .errcode   (errcode)
  );

  always #5 clksys = ~clksys;

  function automatic logic [255:0] rep(input logic [7:0] b);
    return {32{b}};
  endfunction

  task automatic tick();
    @(posedge clksys);
    #1;
  endtask

  task automatic send(input logic [6:0] i, input logic [255:0] d);
    brvld = 1'b1;
    bridx = i;
    brdat = d;
    tick();
    brvld = 1'b0;
  endtask

  task automatic do_reset();
    brvld = 1'b0;
    brdone = 1'b0;
    hold = 1'b0;
    sysresetn = 1'b0;
    tick();
    sysresetn = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    sysresetn = 1'b0;
    #2;
    checks++;
    if ({brready, cfgvld, brerr, errcode} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0",
               {brready, cfgvld, brerr, errcode});
    end
    checks++;
    if (cfgdat !== '0 || cfgsig !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got sig %h exp 0", cfgsig);
    end
    tick();
    sysresetn = 1'b1;
    tick();
    tick();
    checks++;
    if (brready !== 1'b1) begin
      errors++;
      $display("FAIL reset_brready got %b exp 1", brready);
    end
  endtask

  task automatic test_normal();
    do_reset();
    for (int i = 0; i < 3; i++)
      send(7'(i), rep(8'(i)));
    checks++;
    if (cfgvld !== 1'b0) begin
      errors++;
      $display("FAIL normal_early_vld got %b exp 0", cfgvld);
    end
    send(7'd3, rep(8'd3));
    checks++;
    if (cfgvld !== 1'b1) begin
      errors++;
      $display("FAIL normal_vld got %b exp 1", cfgvld);
    end
    for (int i = 4; i < 128; i++)
      send(7'(i), rep(8'(i)));
    brdone = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (cfgdat[k] !== rep(8'(k + 1))) begin
        errors++;
        $display("FAIL normal_dat%0d got %h exp %h",
                 k, cfgdat[k], rep(8'(k + 1)));
      end
    end
    checks++;
    if ({cfgvld, brerr, errcode, cfgsig} !== {1'b1, 1'b0, 2'd0, 32'h0}) begin
      errors++;
      $display("FAIL normal_stat got vld %b err %b code %0d sig %h exp 1 0 0 0",
               cfgvld, brerr, errcode, cfgsig);
    end
    brdone = 1'b0;
  endtask

  task automatic test_skip();
    do_reset();
    send(7'd0, rep(8'd0));
    send(7'd1, rep(8'd1));
    send(7'd3, rep(8'd3));
    checks++;
    if ({brerr, errcode, cfgvld} !== {1'b1, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL skip_stat got err %b code %0d vld %b exp 1 1 0",
               brerr, errcode, cfgvld);
    end
    checks++;
    if (cfgdat[2] !== '0 || cfgdat[0] !== rep(8'd1)) begin
      errors++;
      $display("FAIL skip_dat got %h %h exp 0 %h",
               cfgdat[2], cfgdat[0], rep(8'd1));
    end
  endtask

  task automatic test_early_done();
    logic [255:0] d1;
    logic [255:0] d2;
    d1 = {192'h0, 32'h0000_0100, 32'h0000_0001};
    d2 = {32'hF000_0000, 224'h0};
    do_reset();
    send(7'd0, rep(8'd0));
    send(7'd1, d1);
    send(7'd2, d2);
    brdone = 1'b1;
    tick();
    checks++;
    if ({brerr, errcode, cfgvld} !== {1'b1, 2'd2, 1'b0}) begin
      errors++;
      $display("FAIL early_stat got err %b code %0d vld %b exp 1 2 0",
               brerr, errcode, cfgvld);
    end
    checks++;
    if (cfgdat[0] !== d1 || cfgdat[1] !== d2 || cfgdat[2] !== '0) begin
      errors++;
      $display("FAIL early_dat got %h %h exp %h %h",
               cfgdat[0], cfgdat[1], d1, d2);
    end
    checks++;
    if (cfgsig !== 32'hF000_0202) begin
      errors++;
      $display("FAIL early_sig got %h exp f0000202", cfgsig);
    end
    brdone = 1'b0;
  endtask

  task automatic test_protocol();
    do_reset();
    hold = 1'b1;
    tick();
    checks++;
    if (brready !== 1'b0) begin
      errors++;
      $display("FAIL prot_brready got %b exp 0", brready);
    end
    send(7'd0, rep(8'd0));
    checks++;
    if ({brerr, errcode} !== {1'b1, 2'd3}) begin
      errors++;
      $display("FAIL prot_stat got err %b code %0d exp 1 3",
               brerr, errcode);
    end
    hold = 1'b0;
    tick();
    checks++;
    if (brready !== 1'b1) begin
      errors++;
      $display("FAIL prot_fail_ready got %b exp 1", brready);
    end
    for (int i = 1; i < 4; i++)
      send(7'(i), rep(8'(i)));
    checks++;
    if (cfgdat !== '0 || cfgsig !== 32'h0 || cfgvld !== 1'b0 ||
        errcode !== 2'd3) begin
      errors++;
      $display("FAIL prot_frozen got vld %b code %0d exp 0 3",
               cfgvld, errcode);
    end
  endtask

  task automatic test_simul();
    do_reset();
    for (int i = 0; i < 3; i++)
      send(7'(i), rep(8'(i)));
    brdone = 1'b1;
    send(7'd3, rep(8'd3));
    tick();
    checks++;
    if ({cfgvld, brerr, errcode} !== {1'b1, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL simul_stat got vld %b err %b code %0d exp 1 0 0",
               cfgvld, brerr, errcode);
    end
    checks++;
    if (cfgdat[2] !== rep(8'd3)) begin
      errors++;
      $display("FAIL simul_dat got %h exp %h", cfgdat[2], rep(8'd3));
    end
    brdone = 1'b0;
  endtask

  task automatic test_reset_replay();
    logic [255:0] d;
    do_reset();
    for (int i = 0; i < 3; i++)
      send(7'(i), rep(8'(i)));
    #2;
    sysresetn = 1'b0;
    #1;
    checks++;
    if (cfgdat !== '0 || {brready, cfgvld, brerr, errcode} !== 5'b0) begin
      errors++;
      $display("FAIL replay_async got rdy %b vld %b exp 0 0",
               brready, cfgvld);
    end
    tick();
    sysresetn = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 128; i++) begin
      case (i)
        1:       d = {224'h0, 32'h8000_0001};
        2:       d = {224'h0, 32'h0000_0002};
        3:       d = {224'h0, 32'h0000_0004};
        default: d = {256{1'b1}};
      endcase
      send(7'(i), d);
    end
    checks++;
    if (cfgdat[0] !== {224'h0, 32'h8000_0001} ||
        cfgdat[1] !== {224'h0, 32'h0000_0002} ||
        cfgdat[2] !== {224'h0, 32'h0000_0004}) begin
      errors++;
      $display("FAIL replay_dat got %h %h %h",
               cfgdat[0][31:0], cfgdat[1][31:0], cfgdat[2][31:0]);
    end
    checks++;
    if (cfgsig !== 32'h0000_0006) begin
      errors++;
      $display("FAIL replay_sig got %h exp 00000006", cfgsig);
    end
    checks++;
    if ({cfgvld, brerr} !== 2'b10) begin
      errors++;
      $display("FAIL replay_stat got vld %b err %b exp 1 0",
               cfgvld, brerr);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_skip();
    test_early_done();
    test_protocol();
    test_simul();
    test_reset_replay();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
